instr_fetch: RTL and testbench

Instruction fetch stage sitting directly upstream of the instruction cache. It owns the program counter, issues one word request at a time to the cache using the cache's level-sensitive read_enable/send_enable handshake, and captures the returned 32-bit instruction. Captured instructions go into a small FIFO that feeds decode through a valid/ready interface. Branch redirects flush the FIFO and the in-flight fetch.

---
 rtl/instr_fetch.sv | 151 +++++++++++++++
 tb/tb_instr_fetch.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage: PC, icache handshake, instruction FIFO, redirect flush
//
// Purpose:
//   Owns the program counter. Keeps at most one word request outstanding to
//   the instruction cache. Each returned instruction is queued with its PC in
//   a small FIFO that feeds decode. A redirect empties the FIFO, reloads the
//   PC and discards the response of a request already in flight.
//
// Ports:
//   clock               rising-edge clock
//   reset               asynchronous, active-low; clears all state while low
//   redirect_valid      one-cycle pulse: restart fetch at redirect_pc
//   redirect_pc         new fetch address (bits [1:0] ignored)
//   icache_read_enable  registered request, held until send_enable is seen
//   icache_address      registered word-aligned fetch address
//   icache_data         cache return, instruction in bits [31:0]
//   icache_send_enable  cache data valid, held until read_enable drops
//   instr_valid         FIFO head valid
//   instr_ready         decode accepts the head this cycle
//   instr               FIFO head instruction
//   instr_pc            FIFO head PC
module instr_fetch #(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        icache_read_enable,
  output logic [63:0] icache_address,
  input  logic [63:0] icache_data,
  input  logic        icache_send_enable,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [63:0] instr_pc
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [63:0]      pc, pc_n;
  logic [63:0]      addr_n;
  logic             re_n;
  logic             drop, drop_n;
  logic             push, pop;
  logic [63:0]      redirect_aligned;
  logic [CNT_W-1:0] count, count_after;
  logic [PTR_W-1:0] head, tail;
  logic [31:0]      fifo_instr [FIFO_DEPTH];
  logic [63:0]      fifo_pc    [FIFO_DEPTH];
  logic             unused_bits;

  assign unused_bits      = ^{icache_data[63:32], redirect_pc[1:0]};
  assign redirect_aligned = {redirect_pc[63:2], 2'b00};

  assign instr_valid = (count != '0);
  assign instr       = fifo_instr[head];
  assign instr_pc    = fifo_pc[head];
  assign pop         = instr_valid && instr_ready;

  // Occupancy as it will be after this edge; a redirect empties the FIFO,
  // so an IDLE issue in that cycle always sees room.
  assign count_after = redirect_valid ? '0 : (count - CNT_W'(pop));

  always_comb begin
    state_n = state;
    pc_n    = pc;
    addr_n  = icache_address;
    re_n    = icache_read_enable;
    drop_n  = drop;
    push    = 1'b0;
    case (state)
      IDLE: begin
        if (count_after < DEPTH_C) begin
          state_n = REQ;
          re_n    = 1'b1;
          addr_n  = redirect_valid ? redirect_aligned : pc;
        end
      end
      REQ: begin
        if (icache_send_enable) begin
          // A redirect landing on the response cycle consumes this response
          // directly, so drop is cleared rather than armed for the next one.
          push    = !drop && !redirect_valid;
          if (!drop) pc_n = pc + 64'd4;
          drop_n  = 1'b0;
          re_n    = 1'b0;
          state_n = RELEASE;
        end else if (redirect_valid) begin
          drop_n = 1'b1;
        end
      end
      RELEASE: begin
        if (!icache_send_enable) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (redirect_valid) pc_n = redirect_aligned;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state              <= IDLE;
      pc                 <= RESET_PC;
      drop               <= 1'b0;
      icache_read_enable <= 1'b0;
      icache_address     <= RESET_PC;
    end else begin
      state              <= state_n;
      pc                 <= pc_n;
      drop               <= drop_n;
      icache_read_enable <= re_n;
      icache_address     <= addr_n;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_instr[i] <= '0;
        fifo_pc[i]    <= '0;
      end
    end else if (redirect_valid) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        fifo_instr[tail] <= icache_data[31:0];
        fifo_pc[tail]    <= pc;
        tail             <= tail + PTR_W'(1);
      end
      if (pop) head <= head + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch
module tb_instr_fetch;

  localparam logic [63:0] RST_PC = 64'h1000;

  logic        clock = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        icache_read_enable;
  logic [63:0] icache_address;
  logic [63:0] icache_data;
  logic        icache_send_enable;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [63:0] instr_pc;

  int n_cmp = 0;
  int n_bad = 0;
  int lat;
  int rlag;
  logic [63:0] exp_pc;
  logic [63:0] log_pc[$];
  logic [31:0] log_instr[$];

  instr_fetch #(.RESET_PC(RST_PC), .FIFO_DEPTH(2)) dut (
    .clock              (clock),
    .reset              (reset),
    .redirect_valid     (redirect_valid),
    .redirect_pc        (redirect_pc),
    .icache_read_enable (icache_read_enable),
    .icache_address     (icache_address),
    .icache_data        (icache_data),
    .icache_send_enable (icache_send_enable),
    .instr_valid        (instr_valid),
    .instr_ready        (instr_ready),
    .instr              (instr),
    .instr_pc           (instr_pc)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] word_at(input logic [63:0] a);
    logic [31:0] d;
    d = a[31:0] - 32'h1000;
    return 32'hA0 + (d >> 2);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out", name);
  endtask

  task automatic wait_re_rise(input string name);
    logic p;
    bit   seen;
    p    = icache_read_enable;
    seen = 0;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(negedge clock);
      if (icache_read_enable && !p) seen = 1;
      p = icache_read_enable;
    end
    if (!seen) timeout(name);
  endtask

  task automatic wait_log(input string name, input int n);
    for (int i = 0; i < 80 && log_pc.size() < n; i++) @(negedge clock);
    if (log_pc.size() < n) timeout(name);
  endtask

  // Cache responder: raises send_enable lat cycles after seeing a request,
  // keeps it up rlag cycles after read_enable falls.
  initial begin : cache_model
    int wait_cnt;
    int rel_cnt;
    icache_send_enable = 1'b0;
    icache_data        = '0;
    wait_cnt           = 0;
    rel_cnt            = 0;
    forever begin
      @(posedge clock);
      #1;
      if (!reset) begin
        icache_send_enable = 1'b0;
        wait_cnt = 0;
        rel_cnt  = 0;
      end else if (icache_read_enable && !icache_send_enable) begin
        if (wait_cnt >= lat) begin
          icache_send_enable = 1'b1;
          icache_data        = {32'hFFFF_FFFF, word_at(icache_address)};
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else if (!icache_read_enable && icache_send_enable) begin
        if (rel_cnt >= rlag) begin
          icache_send_enable = 1'b0;
          rel_cnt = 0;
        end else begin
          rel_cnt++;
        end
      end
    end
  end

  // Stream model: delivered PCs are consecutive words starting at the reset
  // PC or the latest redirect target; each carries the word the cache holds
  // at that address.
  initial begin : compare
    logic        prev_re;
    logic        prev_send;
    logic [63:0] prev_addr;
    bit          expect_empty;
    prev_re = 0; prev_send = 0; prev_addr = '0; expect_empty = 0;
    exp_pc  = RST_PC;
    forever begin
      @(negedge clock);
      if (!reset) begin
        exp_pc = RST_PC;
        prev_re = 0; prev_send = 0; expect_empty = 0;
      end else begin
        if (expect_empty) check("flush_empty", {63'd0, instr_valid}, 64'd0);
        expect_empty = 0;
        if (prev_re && icache_read_enable) check("addr_stable", icache_address, prev_addr);
        if (!prev_re && icache_read_enable) check("issue_after_send_low", {63'd0, prev_send}, 64'd0);
        if (redirect_valid) begin
          exp_pc = {redirect_pc[63:2], 2'b00};
          expect_empty = 1;
        end else if (instr_valid && instr_ready) begin
          check("stream_pc", instr_pc, exp_pc);
          check("stream_instr", {32'd0, instr}, {32'd0, word_at(exp_pc)});
          log_pc.push_back(instr_pc);
          log_instr.push_back(instr);
          exp_pc = exp_pc + 64'd4;
        end
        prev_re   = icache_read_enable;
        prev_send = icache_send_enable;
        prev_addr = icache_address;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int   rises;
    logic p;
    bit   hit;
    reset = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
    lat = 1; rlag = 0;

    // reset values
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_read_enable", {63'd0, icache_read_enable}, 64'd0);
    check("rst_address", icache_address, 64'h1000);
    check("rst_instr_valid", {63'd0, instr_valid}, 64'd0);
    check("rst_instr", {32'd0, instr}, 64'd0);
    check("rst_instr_pc", instr_pc, 64'd0);
    @(posedge clock); #1;
    reset = 1'b1; instr_ready = 1'b1;
    @(negedge clock);
    check("pre_first_edge_re", {63'd0, icache_read_enable}, 64'd0);
    @(negedge clock);
    check("first_re", {63'd0, icache_read_enable}, 64'd1);
    check("first_address", icache_address, 64'h1000);

    // sequential fetch
    wait_log("seq_wait", 3);
    if (log_pc.size() >= 3) begin
      check("seq0_instr", {32'd0, log_instr[0]}, 64'hA0);
      check("seq0_pc", log_pc[0], 64'h1000);
      check("seq1_instr", {32'd0, log_instr[1]}, 64'hA1);
      check("seq1_pc", log_pc[1], 64'h1004);
      check("seq2_instr", {32'd0, log_instr[2]}, 64'hA2);
      check("seq2_pc", log_pc[2], 64'h1008);
    end

    // backpressure
    @(posedge clock); #1;
    instr_ready = 1'b0;
    repeat (30) @(posedge clock);
    @(negedge clock);
    check("bp_full_valid", {63'd0, instr_valid}, 64'd1);
    check("bp_idle_re", {63'd0, icache_read_enable}, 64'd0);
    rises = 0; p = icache_read_enable;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (icache_read_enable && !p) rises++;
      p = icache_read_enable;
    end
    check("bp_no_third_request", rises, 0);
    @(posedge clock); #1;
    instr_ready = 1'b1;
    @(posedge clock); #1;
    instr_ready = 1'b0;
    rises = 0; p = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (icache_read_enable && !p) rises++;
      p = icache_read_enable;
    end
    check("bp_one_new_request", rises, 1);
    @(posedge clock); #1;
    instr_ready = 1'b1;
    @(negedge clock);
    check("bp_buffered_1", {63'd0, instr_valid}, 64'd1);
    @(negedge clock);
    check("bp_buffered_2", {63'd0, instr_valid}, 64'd1);
    @(negedge clock);
    check("bp_buffered_only_2", {63'd0, instr_valid}, 64'd0);

    // redirect while waiting in REQ
    lat = 6;
    wait_re_rise("rq_wait_req");
    @(posedge clock); #1;
    redirect_valid = 1'b1; redirect_pc = 64'h2002;
    log_pc.delete(); log_instr.delete();
    @(posedge clock); #1;
    redirect_valid = 1'b0;
    @(negedge clock);
    check("rq_fifo_empty", {63'd0, instr_valid}, 64'd0);
    wait_re_rise("rq_wait_reissue");
    check("rq_next_address", icache_address, 64'h2000);
    wait_log("rq_wait_deliver", 1);
    if (log_pc.size() >= 1) begin
      check("rq_first_pc", log_pc[0], 64'h2000);
      check("rq_first_instr", {32'd0, log_instr[0]}, 64'h4A0);
    end

    // redirect coincident with send_enable and a pop
    lat = 2; rlag = 2;
    @(posedge clock); #1;
    instr_ready = 1'b0;
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(posedge clock); #2;
      if (instr_valid && icache_read_enable && icache_send_enable) hit = 1;
    end
    if (!hit) timeout("co_wait_send");
    redirect_valid = 1'b1; redirect_pc = 64'h3000; instr_ready = 1'b1;
    log_pc.delete(); log_instr.delete();
    @(posedge clock); #1;
    redirect_valid = 1'b0;
    @(negedge clock);
    check("co_fifo_empty", {63'd0, instr_valid}, 64'd0);
    check("co_re_released", {63'd0, icache_read_enable}, 64'd0);
    wait_re_rise("co_wait_reissue");
    check("co_next_address", icache_address, 64'h3000);
    wait_log("co_wait_deliver", 1);
    if (log_pc.size() >= 1) begin
      check("co_first_pc", log_pc[0], 64'h3000);
      check("co_first_instr", {32'd0, log_instr[0]}, 64'h8A0);
    end

    // asynchronous reset in the middle of a request
    lat = 5; rlag = 0;
    wait_re_rise("ar_wait_req");
    @(posedge clock); #3;
    reset = 1'b0;
    #1;
    check("ar_re_async", {63'd0, icache_read_enable}, 64'd0);
    check("ar_address_async", icache_address, 64'h1000);
    check("ar_valid_async", {63'd0, instr_valid}, 64'd0);
    repeat (2) @(posedge clock);
    @(posedge clock); #2;
    reset = 1'b1;
    log_pc.delete(); log_instr.delete();
    wait_re_rise("ar_wait_restart");
    check("ar_restart_address", icache_address, 64'h1000);
    wait_log("ar_wait_deliver", 1);
    if (log_pc.size() >= 1) begin
      check("ar_first_pc", log_pc[0], 64'h1000);
      check("ar_first_instr", {32'd0, log_instr[0]}, 64'hA0);
    end

    repeat (5) @(posedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
